// File: rtl/sdspi_pkg.sv
// Shared types and helpers for the sdspi block engines.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, err status codes, SD token constants, and the CRC16-CCITT byte step.
package sdspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HUNT = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC1 = 3'd3,
    ST_CRC2 = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_TOKEN   = 2'd3;

  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  // One byte of CRC16-CCITT, MSB first, no reflection, no final XOR.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sdspi_crc16.sv
// CRC16-CCITT accumulator, one byte per enabled cycle; clear has priority over enable.
// Latency: crc reflects a byte on the cycle after en.
// Backpressure: none; caller gates en.
// Ports: clk, reset_n, clr (reset to 0x0000), en (fold din), din[7:0], crc[15:0].
module sdspi_crc16
  import sdspi_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= 16'h0000;
    else if (clr)  crc <= 16'h0000;
    else if (en)   crc <= crc16_ccitt_byte(crc, din);
  end

endmodule

// File: rtl/sdspi_blockrd.sv
// SD sector-read engine: hunts the start token, packs the block into 32-bit words, checks CRC16.
// Latency: mem_we one cycle after the 4th byte of a word is popped; done one cycle after the last CRC byte.
// Backpressure: pops only on rx_avail (max 1 byte / 2 cycles); dummy pushes only on tx_ready, limited to MAX_AHEAD in flight.
// Ports: start/abort/base_addr in, busy/done/err out (CPU side); rx_data/rx_avail/rx_read (sdspi RX FIFO);
//        tx_data/tx_write/tx_ready (sdspi TX FIFO); mem_addr/mem_wdata/mem_we (buffer RAM).
module sdspi_blockrd
  import sdspi_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int BLOCK_BYTES   = 512,
  parameter int TIMEOUT_BYTES = 4096,
  parameter int MAX_AHEAD     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  input  logic [7:0]        rx_data,
  input  logic              rx_avail,
  output logic              rx_read,
  output logic [7:0]        tx_data,
  output logic              tx_write,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we
);

  // Byte counter must also hold "bytes still needed" including the two CRC bytes.
  localparam int BC_W = $clog2(BLOCK_BYTES + 3);
  localparam int HC_W = $clog2(TIMEOUT_BYTES + 1);
  localparam int OC_W = $clog2(MAX_AHEAD + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [HC_W-1:0]   hunt_cnt_q;
  logic [OC_W-1:0]   outst_q;
  logic              settle_q;
  logic [23:0]       shift_q;
  logic [7:0]        crc_hi_q;
  logic [15:0]       crc_val;

  logic              active, pop, push, start_ok, abort_ok;
  logic              hunt_last, byte_last;
  logic [BC_W-1:0]   need;

  assign active    = state_q inside {ST_HUNT, ST_DATA, ST_CRC1, ST_CRC2};
  assign abort_ok  = abort && (state_q != ST_IDLE);
  assign start_ok  = start && !abort && (state_q == ST_IDLE);
  // The settle cycle after each pop lets the sdspi FIFO tail catch up before rx_avail is trusted again.
  assign pop       = active && !abort && rx_avail && !settle_q;
  assign hunt_last = (hunt_cnt_q == HC_W'(TIMEOUT_BYTES - 1));
  assign byte_last = (byte_cnt_q == BC_W'(BLOCK_BYTES - 1));

  // Bytes still to be received through CRC2; in HUNT the token position is unknown, so no cap beyond MAX_AHEAD.
  always_comb begin
    need = '0;
    case (state_q)
      ST_DATA: need = BC_W'(BLOCK_BYTES + 2) - byte_cnt_q;
      ST_CRC1: need = BC_W'(2);
      ST_CRC2: need = BC_W'(1);
      default: need = '0;
    endcase
  end

  assign push = active && !abort && tx_ready && (outst_q < OC_W'(MAX_AHEAD)) &&
                ((state_q == ST_HUNT) || (BC_W'(outst_q) < need));

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_HUNT;
      ST_HUNT: if (pop) begin
        if (rx_data == IDLE_BYTE) begin
          if (hunt_last) state_d = ST_DONE;
        end else if (rx_data == START_TOKEN) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DATA: if (pop && byte_last) state_d = ST_CRC1;
      ST_CRC1: if (pop) state_d = ST_CRC2;
      ST_CRC2: if (pop) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_ok) state_d = ST_IDLE;
  end

  // FSM: outputs
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rx_read  = 1'b0;
    tx_write = 1'b0;
    if (state_q != ST_IDLE) busy = 1'b1;
    if (state_q == ST_DONE) done = 1'b1;
    rx_read  = pop;
    tx_write = push;
  end

  assign tx_data = IDLE_BYTE;

  // Datapath: counters, word packing, status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      byte_cnt_q <= '0;
      hunt_cnt_q <= '0;
      outst_q    <= '0;
      settle_q   <= 1'b0;
      shift_q    <= '0;
      crc_hi_q   <= '0;
      err        <= ERR_OK;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (abort_ok) begin
        outst_q  <= '0;
        settle_q <= 1'b0;
      end else begin
        settle_q <= pop;
        if (push && !pop)      outst_q <= outst_q + OC_W'(1);
        else if (pop && !push) outst_q <= outst_q - OC_W'(1);

        if (start_ok) begin
          base_q     <= base_addr;
          err        <= ERR_OK;
          byte_cnt_q <= '0;
          hunt_cnt_q <= '0;
          outst_q    <= '0;
        end

        if (pop) begin
          case (state_q)
            ST_HUNT: begin
              if (rx_data == IDLE_BYTE) begin
                hunt_cnt_q <= hunt_cnt_q + HC_W'(1);
                if (hunt_last) err <= ERR_TIMEOUT;
              end else if (rx_data != START_TOKEN) begin
                err <= ERR_TOKEN;
              end
            end
            ST_DATA: begin
              shift_q    <= {shift_q[15:0], rx_data};
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
              // First byte of a group lands in [31:24]; address wraps naturally at 2^ADDR_W.
              if (byte_cnt_q[1:0] == 2'b11) begin
                mem_wdata <= {shift_q, rx_data};
                mem_addr  <= base_q + ADDR_W'(byte_cnt_q >> 2);
                mem_we    <= 1'b1;
              end
            end
            ST_CRC1: crc_hi_q <= rx_data;
            ST_CRC2: if ({crc_hi_q, rx_data} != crc_val) err <= ERR_CRC;
            default: ;
          endcase
        end
      end
    end
  end

  sdspi_crc16 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_ok),
    .en      (pop && (state_q == ST_DATA)),
    .din     (rx_data),
    .crc     (crc_val)
  );

endmodule

// File: tb/tb_sdspi_blockrd.sv
// Bench for sdspi_blockrd: a card responder answers each dummy byte with the next scripted byte,
// with random rx_avail / tx_ready gating; a queue-based reference model predicts writes, pop count and err.
module tb_sdspi_blockrd;
  import sdspi_pkg::*;

  localparam int MAX_AHEAD = 4;
  localparam int TIMEOUT   = 4096;
  localparam int BLOCK     = 512;

  typedef logic [7:0] u8;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [15:0] base_addr;
  logic        busy, done;
  logic [1:0]  err;
  logic [7:0]  rx_data;
  logic        rx_avail, rx_read;
  logic [7:0]  tx_data;
  logic        tx_write, tx_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;

  int total = 0;
  int bad   = 0;

  u8           script[$];
  u8           rxq[$];
  int          model_out, pops, done_cnt, viol;
  logic        prev_rd;
  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_pops;
  logic [1:0]  exp_err;

  always #5 clk = ~clk;

  sdspi_blockrd dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .rx_read   (rx_read),
    .tx_data   (tx_data),
    .tx_write  (tx_write),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic u8 byte_at(input int i);
    return (i < script.size()) ? script[i] : 8'hFF;
  endfunction

  // Plain CRC16-CCITT over a whole message: xor byte into the top, then 8 polynomial steps.
  function automatic logic [15:0] crc_of(input u8 d[$]);
    int c;
    c = 0;
    foreach (d[k]) begin
      c = c ^ (int'(d[k]) << 8);
      repeat (8) c = ((c & 'h8000) != 0) ? (((c << 1) ^ 'h1021) & 'hFFFF) : ((c << 1) & 'hFFFF);
    end
    return 16'(c);
  endfunction

  // Reference: walk the scripted card response as the protocol reads it.
  task automatic predict(input logic [15:0] base);
    int i, ffs;
    u8  b;
    u8  blk[$];
    exp_addr.delete();
    exp_data.delete();
    i = 0;
    ffs = 0;
    forever begin
      b = byte_at(i);
      i++;
      if (b == 8'hFF) begin
        ffs++;
        if (ffs == TIMEOUT) begin exp_pops = i; exp_err = ERR_TIMEOUT; return; end
      end else if (b == 8'hFE) begin
        break;
      end else begin
        exp_pops = i; exp_err = ERR_TOKEN; return;
      end
    end
    for (int k = 0; k < BLOCK; k++) begin
      blk.push_back(byte_at(i));
      i++;
      if (k % 4 == 3) begin
        exp_data.push_back({blk[k-3], blk[k-2], blk[k-1], blk[k]});
        exp_addr.push_back(base + 16'(k / 4));
      end
    end
    exp_err  = (crc_of(blk) == {byte_at(i), byte_at(i + 1)}) ? ERR_OK : ERR_CRC;
    exp_pops = i + 2;
  endtask

  // One clock: drive inputs at negedge, observe settled outputs 1 time unit later.
  task automatic step(input logic st, input logic ab);
    @(negedge clk);
    start    = st;
    abort    = ab;
    tx_ready = ($urandom_range(0, 4) != 0);
    if (rxq.size() > 0 && $urandom_range(0, 3) != 0) begin
      rx_avail = 1'b1;
      rx_data  = rxq[0];
    end else begin
      rx_avail = 1'b0;
      rx_data  = 8'($urandom);
    end
    #1;
    if (tx_write && model_out >= MAX_AHEAD) viol++;
    if (rx_read && (prev_rd || !rx_avail))  viol++;
    prev_rd = rx_read;
    if (done) done_cnt++;
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
    if (rx_read) begin
      void'(rxq.pop_front());
      pops++;
      model_out--;
    end
    if (tx_write) begin
      rxq.push_back((script.size() > 0) ? script.pop_front() : 8'hFF);
      model_out++;
    end
  endtask

  task automatic clear_obs();
    rxq.delete();
    got_addr.delete();
    got_data.delete();
    model_out = 0;
    pops      = 0;
    done_cnt  = 0;
    viol      = 0;
    prev_rd   = 1'b0;
  endtask

  task automatic make_block(input int nff, input bit rnd, input bit corrupt);
    u8 blk[$];
    logic [15:0] c;
    script.delete();
    repeat (nff) script.push_back(8'hFF);
    script.push_back(8'hFE);
    for (int k = 0; k < BLOCK; k++) blk.push_back(rnd ? 8'($urandom) : 8'(k));
    foreach (blk[k]) script.push_back(blk[k]);
    c = crc_of(blk);
    script.push_back(c[15:8]);
    script.push_back(corrupt ? (c[7:0] ^ 8'h01) : c[7:0]);
  endtask

  task automatic run_read(input string tag, input logic [15:0] base);
    int cyc, mism;
    predict(base);
    clear_obs();
    base_addr = base;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "/err_cleared"}, 32'(err), 32'(ERR_OK));
    cyc = 0;
    while (done_cnt == 0 && cyc < 40000) begin
      step(1'b0, 1'b0);
      cyc++;
    end
    chk({tag, "/done_seen"}, done_cnt, 1);
    chk({tag, "/err"}, 32'(err), 32'(exp_err));
    repeat (3) step(1'b0, 1'b0);
    chk({tag, "/done_once"}, done_cnt, 1);
    chk({tag, "/busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "/n_writes"}, got_addr.size(), exp_addr.size());
    mism = 0;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) mism++;
    chk({tag, "/write_mismatches"}, mism, 0);
    chk({tag, "/pops"}, pops, exp_pops);
    chk({tag, "/flow_violations"}, viol, 0);
    if (exp_err == ERR_OK || exp_err == ERR_CRC) chk({tag, "/outstanding_end"}, model_out, 0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
    tx_ready = 1'b0; rx_avail = 1'b0; rx_data = '0;
    clear_obs();
    #1;
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk("rst/rx_read", 32'(rx_read), 32'd0);
    chk("rst/tx_write", 32'(tx_write), 32'd0);
    chk("rst/mem_we", 32'(mem_we), 32'd0);
    chk("rst/mem_addr", 32'(mem_addr), 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    chk("rst/tx_data", 32'(tx_data), 32'hFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // All-0xFF block with its known CRC 0x7FA1.
    script.delete();
    repeat (3) script.push_back(8'hFF);
    script.push_back(8'hFE);
    repeat (BLOCK) script.push_back(8'hFF);
    script.push_back(8'h7F);
    script.push_back(8'hA1);
    run_read("ffblock", 16'h0040);
    chk("ffblock/err_ok", 32'(err), 32'(ERR_OK));
    chk("ffblock/last_addr", (got_addr.size() > 0) ? 32'(got_addr[got_addr.size()-1]) : 32'hDEAD, 32'h00BF);

    // Counting data, base wraps past 0xFFFF.
    make_block(2, 1'b0, 1'b0);
    run_read("wrap", 16'hFFFE);
    chk("wrap/first_word", (got_data.size() > 0) ? got_data[0] : 32'hDEADBEEF, 32'h00010203);
    chk("wrap/third_addr", (got_addr.size() > 2) ? 32'(got_addr[2]) : 32'hDEAD, 32'h0000);

    // Same block, CRC low byte corrupted.
    make_block(1, 1'b0, 1'b1);
    run_read("badcrc", 16'h1000);
    chk("badcrc/err_crc", 32'(err), 32'(ERR_CRC));

    // Card never answers with a token.
    script.delete();
    run_read("timeout", 16'h0000);
    chk("timeout/err_code", 32'(err), 32'(ERR_TIMEOUT));

    // Data error token, then a clean retry on random data.
    script.delete();
    script.push_back(8'hFF);
    script.push_back(8'hFF);
    script.push_back(8'h05);
    run_read("token", 16'h0200);
    chk("token/err_code", 32'(err), 32'(ERR_TOKEN));
    make_block($urandom_range(0, 20), 1'b1, 1'b0);
    run_read("retry", 16'($urandom));

    // Abort after 100 data bytes.
    make_block(2, 1'b0, 1'b0);
    clear_obs();
    base_addr = 16'h0100;
    step(1'b1, 1'b0);
    cyc = 0;
    while (got_addr.size() < 25 && cyc < 5000) begin step(1'b0, 1'b0); cyc++; end
    chk("abort/reached_100_bytes", 32'(got_addr.size() >= 25), 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/rx_read", 32'(rx_read), 32'd0);
    chk("abort/tx_write", 32'(tx_write), 32'd0);
    repeat (5) step(1'b0, 1'b0);
    chk("abort/no_done", done_cnt, 0);
    chk("abort/err_kept", 32'(err), 32'(ERR_OK));
    chk("abort/flow_violations", viol, 0);

    // Asynchronous reset mid-block.
    make_block(2, 1'b0, 1'b0);
    clear_obs();
    base_addr = 16'h0300;
    step(1'b1, 1'b0);
    cyc = 0;
    while (got_addr.size() < 10 && cyc < 5000) begin step(1'b0, 1'b0); cyc++; end
    chk("arst/midblock", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst/busy", 32'(busy), 32'd0);
    chk("arst/done", 32'(done), 32'd0);
    chk("arst/err", 32'(err), 32'd0);
    chk("arst/rx_read", 32'(rx_read), 32'd0);
    chk("arst/tx_write", 32'(tx_write), 32'd0);
    chk("arst/mem_we", 32'(mem_we), 32'd0);
    chk("arst/mem_addr", 32'(mem_addr), 32'd0);
    chk("arst/mem_wdata", mem_wdata, 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    chk("arst/idle_after", 32'(busy), 32'd0);
    chk("arst/no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
